// File: rtl/dreimann_button_rx.sv
// Roll-button conditioner: two-flop synchroniser, debouncer, short/long press
// classifier and a one-entry valid/ready event slot with sticky overflow.
module dreimann_button_rx #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LONG_CYCLES     = 200,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_ovf
);

  typedef enum logic [1:0] {REL, HELD, LONG} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [1:0]       CODE_SHORT = 2'b01;
  localparam logic [1:0]       CODE_LONG  = 2'b10;

  logic             s1, s2;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] hcnt, hcnt_next;
  state_t           state, state_next;
  logic             flip, rise;
  logic             emit;
  logic [1:0]       emit_code;

  assign flip = (s2 != btn_level) && (dcnt == DEB_LAST);
  assign rise = flip && s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      dcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= btn_raw;
      s2            <= s1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (s2 == btn_level) begin
        dcnt <= '0;
      end else if (flip) begin
        btn_level     <= s2;
        dcnt          <= '0;
        press_pulse   <= s2;
        release_pulse <= !s2;
      end else begin
        dcnt <= dcnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= REL;
      hcnt  <= '0;
    end else begin
      state <= state_next;
      hcnt  <= hcnt_next;
    end
  end

  // The FSM enters HELD on the same edge that registers press_pulse, so the
  // long event lands exactly LONG_CYCLES after the pulse; releases are taken
  // from the registered pulse so the short event trails it by one cycle.
  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    case (state)
      REL: ;
      HELD: begin
        if (hcnt == LONG_LAST) begin
          state_next = release_pulse ? REL : LONG;
        end else if (release_pulse) begin
          state_next = REL;
        end else if (btn_level) begin
          hcnt_next = hcnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (release_pulse) state_next = REL;
      end
      default: state_next = REL;
    endcase
    if (rise && (state == REL || release_pulse)) begin
      state_next = HELD;
      hcnt_next  = '0;
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_code = 2'b00;
    if (state == HELD) begin
      if (hcnt == LONG_LAST) begin
        emit      = 1'b1;
        emit_code = CODE_LONG;
      end else if (release_pulse) begin
        emit      = 1'b1;
        emit_code = CODE_SHORT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_code  <= 2'b00;
      evt_ovf   <= 1'b0;
    end else if (emit) begin
      if (!evt_valid || evt_ready) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code;
      end else begin
        evt_ovf <= 1'b1;
      end
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dreimann_button_rx.sv
// Self-checking bench for dreimann_button_rx: directed scenarios plus random
// button activity, all compared against a press-timing reference model.
module tb_dreimann_button_rx;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       evt_ready;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ovf;

  dreimann_button_rx #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_ready(evt_ready),
    .evt_ovf(evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: edge counter, raw-sample history, run length of samples
  // disagreeing with the level, and press/release edge timestamps.
  int         t_now = 0;
  bit         hist[$];
  bit         m_level, m_press, m_release;
  int         run;
  bit         pressing, released;
  int         p_edge, r_edge;
  bit         m_valid, m_ovf;
  logic [1:0] m_code;

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_level   = 1'b0;
    m_press   = 1'b0;
    m_release = 1'b0;
    run       = 0;
    pressing  = 1'b0;
    released  = 1'b0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
    m_code    = 2'b00;
  endtask

  task automatic model_edge();
    bit         emit;
    logic [1:0] code;
    bit         s2;
    t_now++;
    if (rst) begin
      model_reset();
      return;
    end
    emit = 1'b0;
    code = 2'b00;
    // A press is long if the button is still down (or released only on the
    // very last cycle) LONG_CYCLES after the press pulse; otherwise short.
    if (pressing) begin
      if (t_now == p_edge + L && (!released || r_edge == t_now - 1)) begin
        emit = 1'b1; code = 2'b10; pressing = 1'b0;
      end else if (released && t_now == r_edge + 1 && r_edge < p_edge + L - 1) begin
        emit = 1'b1; code = 2'b01; pressing = 1'b0;
      end
    end
    if (emit) begin
      if (!m_valid || evt_ready) begin
        m_valid = 1'b1;
        m_code  = code;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    s2 = hist[0];
    m_press   = 1'b0;
    m_release = 1'b0;
    if (s2 != m_level) run++;
    else run = 0;
    if (run == int'(D)) begin
      m_level = s2;
      run     = 0;
      if (s2) begin
        m_press = 1'b1; pressing = 1'b1; released = 1'b0; p_edge = t_now;
      end else begin
        m_release = 1'b1; released = 1'b1; r_edge = t_now;
      end
    end
    void'(hist.pop_front());
    hist.push_back(btn_raw);
  endtask

  function automatic logic [6:0] exp_vec();
    return {m_level, m_press, m_release, m_valid, m_ovf, m_valid ? m_code : 2'b00};
  endfunction

  function automatic logic [6:0] act_vec();
    return {btn_level, press_pulse, release_pulse, evt_valid, evt_ovf,
            evt_valid ? evt_code : 2'b00};
  endfunction

  task automatic step(input logic raw, input logic rdy);
    btn_raw   = raw;
    evt_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tests++;
      if (act_vec() !== 7'b0) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, act_vec(), 7'b0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      tests++;
      if (act_vec() !== exp_vec() || act_vec() !== 7'b0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_short_press();
    int press_at = -1;
    int rel_at = -1;
    int val_at = -1;
    int hi = $urandom_range(8, 12);
    for (int i = 0; i < hi; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL short_hold cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      if (press_pulse && press_at < 0) press_at = i;
    end
    tests++;
    if (press_at !== 5) begin
      fails++;
      $display("FAIL short_press_latency: got %0d expected 5", press_at);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL short_release cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      if (release_pulse && rel_at < 0) rel_at = i;
      if (evt_valid && val_at < 0) val_at = i;
    end
    tests++;
    if (rel_at !== 5 || val_at !== 6) begin
      fails++;
      $display("FAIL short_event_timing: got release %0d valid %0d expected 5 6", rel_at, val_at);
    end
    tests++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin
      fails++;
      $display("FAIL short_code: got valid %b code %b expected 1 01", evt_valid, evt_code);
    end
    step(1'b0, 1'b1);
    tests++;
    if (evt_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL short_ack: got %b expected %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_bounce();
    for (int g = 0; g < 5; g++) begin
      int hl = $urandom_range(1, 3);
      for (int i = 0; i < hl + 3; i++) begin
        step(i < hl, 1'b0);
        tests++;
        if (act_vec() !== exp_vec() || {btn_level, press_pulse, release_pulse, evt_valid} !== 4'b0) begin
          fails++;
          $display("FAIL bounce glitch %0d: got %b expected %b", g, act_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_long_press();
    int press_at = -1;
    int val_at = -1;
    int rel_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL long_hold cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      if (press_pulse && press_at < 0) press_at = i;
      if (evt_valid && val_at < 0) val_at = i;
    end
    tests++;
    if (press_at !== 5 || val_at - press_at !== int'(L)) begin
      fails++;
      $display("FAIL long_timing: got press %0d valid %0d expected 5 25", press_at, val_at);
    end
    tests++;
    if (evt_code !== 2'b10) begin
      fails++;
      $display("FAIL long_code: got %b expected 10", evt_code);
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL long_release cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      if (release_pulse) rel_cnt++;
    end
    tests++;
    if (rel_cnt !== 1 || {evt_valid, evt_code, evt_ovf} !== 4'b1100) begin
      fails++;
      $display("FAIL long_single_event: got releases %0d state %b expected 1 1100",
               rel_cnt, {evt_valid, evt_code, evt_ovf});
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 22; i++) begin
        step(i < 10, 1'b0);
        tests++;
        if (act_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL ovf_press %0d cycle %0d: got %b expected %b", p, i, act_vec(), exp_vec());
        end
      end
    end
    tests++;
    if ({evt_valid, evt_code, evt_ovf} !== 4'b1011) begin
      fails++;
      $display("FAIL ovf_retain: got %b expected 1011", {evt_valid, evt_code, evt_ovf});
    end
    step(1'b0, 1'b1);
    tests++;
    if ({evt_valid, evt_ovf} !== 2'b01) begin
      fails++;
      $display("FAIL ovf_sticky: got %b expected 01", {evt_valid, evt_ovf});
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    int press_at = -1;
    int val_at = -1;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL midrst_pre cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if (act_vec() !== 7'b0 || evt_code !== 2'b00) begin
      fails++;
      $display("FAIL midrst_async: got %b code %b expected all zero", act_vec(), evt_code);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      step(1'b1, 1'b0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL midrst_post cycle %0d: got %b expected %b", i, act_vec(), exp_vec());
      end
      if (press_pulse && press_at < 0) press_at = i;
      if (evt_valid && val_at < 0) val_at = i;
    end
    tests++;
    if (press_at !== 5 || val_at !== 25 || evt_code !== 2'b10) begin
      fails++;
      $display("FAIL midrst_event: got press %0d valid %0d code %b expected 5 25 10",
               press_at, val_at, evt_code);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int   n = 0;
    while (n < 1500) begin
      int seg = $urandom_range(1, 30);
      lvl = ~lvl;
      for (int i = 0; i < seg; i++) begin
        step(lvl, $urandom_range(0, 3) == 0);
        n++;
        tests++;
        if (act_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL random cycle %0d: got %b expected %b", n, act_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_raw   = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    test_reset();
    test_short_press();
    test_bounce();
    test_long_press();
    test_overflow();
    test_reset_mid_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
